vga_sram_arbiter: RTL and testbench
===================================

# vga_sram_arbiter

- Shares one asynchronous single-port 16-bit SRAM (1M x 16, 20-bit address) between two requesters:
  - the VGA display fetch path, which reads RGB565 pixels;
  - a frame writer, which loads pixels into the framebuffer.
- Display reads have absolute priority and a fixed, deterministic latency.
- Writes are issued only in bus slots that provably cannot delay a scheduled read.
- Sits between the pixel-timing/display logic and the SRAM pins.

## Interface
Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- RD_LAT, 3, display read latency in cycles from disp_req to disp_rvalid; fixed, not tunable

Ports (clock and reset are listed first):
- clk  in  1  single system/pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- disp_req  in  1  display read request; one pixel per asserted cycle, no backpressure
- disp_addr  in  ADDR_W  pixel address, sampled with disp_req
- disp_rvalid  out  1  disp_rdata valid, exactly RD_LAT cycles after the disp_req
- disp_rdata  out  DATA_W  pixel word, RGB565
- wr_valid  in  1  writer request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- sram_addr  out  ADDR_W  registered SRAM address
- sram_dq_out  out  DATA_W  write data to pad
- sram_dq_oe  out  1  pad output enable, 1 = drive
- sram_dq_in  in  DATA_W  read data from pad
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes

## Operation
- **Request delay line.** disp_req/disp_addr pass through a 2-stage delay line, d1 then d2.
  - A request sampled at cycle t occupies the bus in cycle t+2 as a READ.
- **Bus FSM states** (one-hot or encoded via the package enum): IDLE, READ, WRITE, TURN.
  - Drive per state: READ: ce_n=0, oe_n=0, dq_oe=0. WRITE: ce_n=0, we_n=0, dq_oe=1. TURN/IDLE: all strobes high, dq_oe=0.
- **Next-state priority:**
  1. d2 valid → READ.
  2. Else if the last state was WRITE → TURN.
  3. Else if the write is eligible → WRITE.
  4. Else → IDLE.
- **Write eligibility**, all of the following must hold:
  - d2=0 and d1=0, i.e. no read in this slot or the next, which keeps the TURN slot free;
  - the last state is not READ (read-to-write turnaround);
  - a write is pending.
- **Bus turnaround.** A READ always follows WRITE+TURN, so the dq bus never has two drivers.
- **Read data.** sram_dq_in is captured at the end of a READ cycle into disp_rdata; disp_rvalid pulses for one cycle.
  - Back-to-back disp_req produces back-to-back disp_rvalid (full throughput).
- **Write handshake.**
  - Without the buffer, wr_ready is high only in the cycle the FSM enters WRITE. wr_addr/wr_data must be held stable while wr_valid is high (valid/ready rule: no withdrawal).
  - With the buffer, see Configuration.
- **Widths.** Addresses pass through unmodified; no wrap or bounds check. An out-of-range address is the caller's error.

## Timing
- **Reset values (all outputs):**
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0;
  - sram_addr=0, sram_dq_out=0;
  - disp_rvalid=0, disp_rdata=0, wr_ready=0;
  - FSM=IDLE, delay line cleared.
- **Reset mid-operation.**
  - In-flight reads are dropped: no disp_rvalid after reset.
  - A WRITE in progress ends with we_n=1 from the first clock edge where rst is sampled high.
  - A buffered write is discarded.
- **Latency.**
  - disp_req at t → sram_addr=disp_addr in cycle t+2 → disp_rvalid/disp_rdata registered, visible in cycle t+3.
  - This latency is independent of write traffic.
- **Simultaneous disp_req and wr_valid.** The display always wins. A write waits until two consecutive read-free slots follow a non-read cycle.
- **Continuous disp_req** (active video): the writer is starved by design. Writes proceed during blanking.

## Configuration
- SRAM_WR_BUFFER_EN defined:
  - Writer requests enter a 4-entry FIFO.
  - wr_ready = !fifo_full, so the writer streams during active video until the FIFO fills.
  - The FSM drains the FIFO head under the eligibility rules.
  - Write order is preserved.
- SRAM_WR_BUFFER_EN undefined:
  - No FIFO; the direct handshake described above.
  - At most one write per eligible slot.

## Structure
- **Package vga_sram_pkg:**
  - ADDR_W, DATA_W, RD_LAT constants;
  - bus-state enum {IDLE, READ, WRITE, TURN};
  - RGB565 field positions (red 15:11, green 10:5, blue 4:0).
- **Sub-module sram_wr_fifo** (depth 4, width ADDR_W+DATA_W, synchronous, full/empty flags):
  - instantiated only under SRAM_WR_BUFFER_EN.

## Test plan
- **Reset:** assert rst for 2 cycles during a WRITE → next cycle we_n=1, dq_oe=0, disp_rvalid=0; all outputs at reset values.
- **Read latency:** disp_req at t=10 with addr 0x00123, SRAM model returns 0xF800 → disp_rvalid=1 at t=13 with disp_rdata=0xF800; 640 back-to-back requests → 640 consecutive rvalids.
- **Write in blanking:** disp_req=0, wr_valid with addr 0x4B000, data 0x07E0 → WRITE within 1 cycle, we_n=0 for exactly 1 cycle, next state TURN, read-back returns 0x07E0.
- **Contention:** wr_valid held while disp_req toggles 1,0,1 → no WRITE issued, no bus overlap; the write completes only after ≥2 idle d-slots.
- **Turnaround check:** WRITE immediately followed by disp_req → exactly one TURN cycle with dq_oe=0 before READ; disp_rvalid still at t+3.
- **Buffer (SRAM_WR_BUFFER_EN):** 5 writes during continuous disp_req → 4 accepted, wr_ready=0 on the 5th; after disp_req drops, all 4 are written in order, then the 5th is accepted.

Source files
------------

// File: rtl/vga_sram_pkg.sv
// Shared constants and types for the VGA framebuffer SRAM arbiter.
package vga_sram_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } bus_state_t;

  // RGB565 pixel layout
  localparam int RGB_R_HI = 15;
  localparam int RGB_R_LO = 11;
  localparam int RGB_G_HI = 10;
  localparam int RGB_G_LO = 5;
  localparam int RGB_B_HI = 4;
  localparam int RGB_B_LO = 0;

  function automatic logic [15:0] rgb565_pack(input logic [4:0] r, input logic [5:0] g,
                                               input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/vga_sram_arbiter_wr_fifo.sv
// Small synchronous write buffer used when SRAM_WR_BUFFER_EN is defined.
module sram_wr_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_sram_arbiter.sv
// Display-priority arbiter for a shared async SRAM framebuffer.
// Optional 4-deep writer FIFO enabled by defining SRAM_WR_BUFFER_EN.
//
// state | meaning
// IDLE  | bus parked, all strobes high
// READ  | display fetch on the bus, SRAM drives dq
// WRITE | writer word on the bus, arbiter drives dq
// TURN  | dead cycle after WRITE so dq has a single driver
module vga_sram_arbiter #(
  parameter int ADDR_W = vga_sram_pkg::ADDR_W,
  parameter int DATA_W = vga_sram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  import vga_sram_pkg::*;

  bus_state_t        state;
  logic              d1_v;
  logic              d2_v;
  logic [ADDR_W-1:0] d1_a;
  logic              wr_pending;
  logic              wr_issue;
  logic [ADDR_W-1:0] wr_head_addr;
  logic [DATA_W-1:0] wr_head_data;

  // d1 holds the read for the slot being scheduled; d2 marks the slot on the bus now
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_v <= 1'b0;
      d1_a <= '0;
      d2_v <= 1'b0;
    end else begin
      d1_v <= disp_req;
      d1_a <= disp_addr;
      d2_v <= d1_v;
    end
  end

  // A write needs this slot and the next free of reads, and must not follow a READ
  assign wr_issue = !rst && wr_pending && !d1_v && !disp_req &&
                    (state == IDLE || state == TURN);

`ifdef SRAM_WR_BUFFER_EN
  localparam int FIFO_W = ADDR_W + DATA_W;

  logic              fifo_full;
  logic              fifo_empty;
  logic              ready_en;
  logic [FIFO_W-1:0] fifo_head;

  sram_wr_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(4)
  ) u_wr_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_valid && wr_ready),
    .push_data({wr_addr, wr_data}),
    .pop      (wr_issue),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  assign wr_ready                     = ready_en && !fifo_full;
  assign wr_pending                   = !fifo_empty;
  assign {wr_head_addr, wr_head_data} = fifo_head;
`else
  logic wr_ready_q;

  // ready is asserted exactly in the WRITE cycle that consumes the held word
  always_ff @(posedge clk) begin
    if (rst) wr_ready_q <= 1'b0;
    else     wr_ready_q <= wr_issue;
  end

  assign wr_ready     = wr_ready_q;
  assign wr_pending   = wr_valid;
  assign wr_head_addr = wr_addr;
  assign wr_head_data = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else if (d1_v) begin
      state      <= READ;
      sram_ce_n  <= 1'b0;
      sram_oe_n  <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      sram_addr  <= d1_a;
    end else if (state == WRITE) begin
      state      <= TURN;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else if (wr_issue) begin
      state       <= WRITE;
      sram_ce_n   <= 1'b0;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b0;
      sram_dq_oe  <= 1'b1;
      sram_addr   <= wr_head_addr;
      sram_dq_out <= wr_head_data;
    end else begin
      state      <= IDLE;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      disp_rvalid <= d2_v;
      if (d2_v) disp_rdata <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Self-checking bench for vga_sram_arbiter with an async SRAM model and read scoreboard.
module tb_vga_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_in;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;

  vga_sram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_rvalid(disp_rvalid),
    .disp_rdata (disp_rdata),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  rd_exp_t     mon_e;
  logic [35:0] wlog[$];
  int          rv_total = 0;
  int          wr_count = 0;
  int          overlap_cnt = 0;
  int          turn_viol = 0;
  logic        prev_we = 1'b0;

  bit [15:0] mem [0:(1<<20)-1];

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  function automatic logic [15:0] pix(input logic [19:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  // SRAM bus monitor: performs writes, flags contention and missing turnaround
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr] = sram_dq_out;
      wr_count++;
      wlog.push_back({sram_addr, sram_dq_out});
    end
    if (sram_dq_oe && !sram_oe_n) overlap_cnt++;
    if (!sram_oe_n && prev_we) turn_viol++;
    prev_we = !sram_ce_n && !sram_we_n;
  end

  // Read scoreboard: every display read must come back at its due cycle
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (disp_rvalid) begin
      rv_total++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: rvalid=1 at cycle %0d, required no pending read", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.due != cyc || disp_rdata !== mon_e.data) begin
          failures++;
          $display("FAIL rd_scoreboard: got data=%h cycle=%0d, want data=%h cycle=%0d",
                   disp_rdata, cyc, mon_e.data, mon_e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL rd_missing: no rvalid at cycle %0d, want data=%h", cyc, sb[0].data);
      void'(sb.pop_front());
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_read(input logic [19:0] a, input logic [15:0] d);
    rd_exp_t e;
    disp_req  = 1'b1;
    disp_addr = a;
    e.due     = cyc + 3;
    e.data    = d;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      failures++;
      $display("FAIL reset_strobes: got ce/oe/we/oe_dq=%b want 1110",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    checks++;
    if (sram_addr !== 20'h0 || sram_dq_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_bus: got addr=%h dq_out=%h want 0 0", sram_addr, sram_dq_out);
    end
    checks++;
    if ({disp_rvalid, wr_ready} !== 2'b00 || disp_rdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_handshake: got rvalid=%b ready=%b rdata=%h want 0 0 0",
               disp_rvalid, wr_ready, disp_rdata);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_read_latency;
    mem[20'h00123] = 16'hF800;
    push_read(20'h00123, 16'hF800);
    tick;
    disp_req = 1'b0;
    tick;
    checks++;
    if (sram_addr !== 20'h00123 || {sram_ce_n, sram_oe_n, sram_dq_oe} !== 3'b000) begin
      failures++;
      $display("FAIL lat_bus_t2: got addr=%h ce/oe/dq_oe=%b want 00123 000",
               sram_addr, {sram_ce_n, sram_oe_n, sram_dq_oe});
    end
    tick;
    checks++;
    if (disp_rvalid !== 1'b1 || disp_rdata !== 16'hF800) begin
      failures++;
      $display("FAIL lat_rvalid_t3: got rvalid=%b rdata=%h want 1 f800", disp_rvalid, disp_rdata);
    end
    tick;
    checks++;
    if (disp_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL lat_pulse: got rvalid=%b at t+4 want 0", disp_rvalid);
    end
    tick(2);
  endtask

  task automatic test_back_to_back;
    int rv0;
    for (int i = 0; i < 640; i++) mem[20'h01000 + 20'(i)] = pix(20'h01000 + 20'(i));
    rv0 = rv_total;
    for (int i = 0; i < 640; i++) begin
      push_read(20'h01000 + 20'(i), pix(20'h01000 + 20'(i)));
      tick;
    end
    disp_req = 1'b0;
    tick(5);
    checks++;
    if (rv_total - rv0 != 640 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: got rvalids=%0d pending=%0d want 640 0", rv_total - rv0, sb.size());
    end
  endtask

`ifndef SRAM_WR_BUFFER_EN
  task automatic test_write_blanking;
    int w0;
    w0       = wr_count;
    wr_valid = 1'b1;
    wr_addr  = 20'h4B000;
    wr_data  = 16'h07E0;
    tick;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, wr_ready} !== 5'b01011) begin
      failures++;
      $display("FAIL blank_write_slot: got ce/oe/we/dq_oe/ready=%b want 01011",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, wr_ready});
    end
    checks++;
    if (sram_addr !== 20'h4B000 || sram_dq_out !== 16'h07E0) begin
      failures++;
      $display("FAIL blank_write_bus: got addr=%h dq=%h want 4b000 07e0", sram_addr, sram_dq_out);
    end
    tick;
    wr_valid = 1'b0;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, wr_ready} !== 5'b11100) begin
      failures++;
      $display("FAIL blank_turn: got ce/oe/we/dq_oe/ready=%b want 11100",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, wr_ready});
    end
    tick(3);
    checks++;
    if (wr_count - w0 != 1) begin
      failures++;
      $display("FAIL blank_we_cycles: got %0d write cycles want 1", wr_count - w0);
    end
    push_read(20'h4B000, 16'h07E0);
    tick;
    disp_req = 1'b0;
    tick(4);
  endtask

  task automatic test_contention;
    int w0;
    int ov0;
    int k0;
    int wcyc;
    mem[20'h00200] = 16'h1111;
    mem[20'h00201] = 16'h2222;
    w0       = wr_count;
    ov0      = overlap_cnt;
    k0       = cyc;
    wcyc     = -1;
    wr_valid = 1'b1;
    wr_addr  = 20'h0ABCD;
    wr_data  = 16'h001F;
    push_read(20'h00200, 16'h1111);
    tick;
    disp_req = 1'b0;
    tick;
    push_read(20'h00201, 16'h2222);
    tick;
    disp_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (sram_we_n === 1'b0) begin
        wcyc = cyc;
        break;
      end
    end
    checks++;
    if (wcyc != k0 + 6) begin
      failures++;
      $display("FAIL contend_write_cycle: got write at offset %0d want 6 (-1 means none)",
               (wcyc < 0) ? -1 : wcyc - k0);
    end
    tick;
    wr_valid = 1'b0;
    tick(3);
    checks++;
    if (wr_count - w0 != 1 || overlap_cnt != ov0) begin
      failures++;
      $display("FAIL contend_bus: got writes=%0d overlaps=%0d want 1 0",
               wr_count - w0, overlap_cnt - ov0);
    end
    checks++;
    if (wlog.size() == 0 || wlog[wlog.size()-1] !== {20'h0ABCD, 16'h001F}) begin
      failures++;
      $display("FAIL contend_write_word: got %h want 0abcd001f",
               (wlog.size() == 0) ? 36'h0 : wlog[wlog.size()-1]);
    end
  endtask

  task automatic test_turnaround;
    int tv0;
    mem[20'h00300] = 16'hABCD;
    tv0      = turn_viol;
    wr_valid = 1'b1;
    wr_addr  = 20'h00400;
    wr_data  = 16'h5555;
    tick;
    checks++;
    if (sram_we_n !== 1'b0) begin
      failures++;
      $display("FAIL turn_write_first: got we_n=%b want 0", sram_we_n);
    end
    push_read(20'h00300, 16'hABCD);
    tick;
    disp_req = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      failures++;
      $display("FAIL turn_slot: got ce/oe/we/dq_oe=%b want 1110",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    tick;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_dq_oe} !== 3'b000 || sram_addr !== 20'h00300) begin
      failures++;
      $display("FAIL turn_read_slot: got ce/oe/dq_oe=%b addr=%h want 000 00300",
               {sram_ce_n, sram_oe_n, sram_dq_oe}, sram_addr);
    end
    tick(3);
    checks++;
    if (turn_viol != tv0) begin
      failures++;
      $display("FAIL turn_violation: got %0d write-to-read without turn want 0", turn_viol - tv0);
    end
  endtask

  task automatic test_reset_mid_op;
    int rv0;
    wr_valid = 1'b1;
    wr_addr  = 20'h00777;
    wr_data  = 16'h1234;
    tick;
    checks++;
    if (sram_we_n !== 1'b0) begin
      failures++;
      $display("FAIL rstw_precond: got we_n=%b want 0", sram_we_n);
    end
    rst      = 1'b1;
    wr_valid = 1'b0;
    tick;
    checks++;
    if ({sram_we_n, sram_dq_oe, disp_rvalid, sram_ce_n} !== 4'b1001) begin
      failures++;
      $display("FAIL rstw_first_edge: got we_n/dq_oe/rvalid/ce_n=%b want 1001",
               {sram_we_n, sram_dq_oe, disp_rvalid, sram_ce_n});
    end
    tick;
    rst = 1'b0;
    tick(2);
    rv0 = rv_total;
    push_read(20'h00123, 16'hF800);
    tick;
    disp_req = 1'b0;
    rst      = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    checks++;
    if (rv_total != rv0) begin
      failures++;
      $display("FAIL rst_drop_read: got %0d rvalids after reset want 0", rv_total - rv0);
    end
  endtask
`else
  task automatic test_buffer;
    int w0;
    int wi;
    int acc;
    logic fire;
    w0  = wr_count;
    wi  = 0;
    for (int i = 0; i < 4; i++) mem[20'h00500 + 20'(i)] = pix(20'h00500 + 20'(i));
    for (int c = 0; c < 12; c++) begin
      push_read(20'h00500 + 20'(c % 4), pix(20'h00500 + 20'(c % 4)));
      wr_valid = 1'b1;
      wr_addr  = 20'h00600 + 20'(wi);
      wr_data  = 16'hB000 + 16'(wi);
      fire     = wr_ready;
      tick;
      if (fire) wi++;
    end
    acc = wi;
    checks++;
    if (acc != 4 || wr_ready !== 1'b0 || wr_count != w0) begin
      failures++;
      $display("FAIL buf_fill: got accepted=%0d ready=%b writes=%0d want 4 0 0",
               acc, wr_ready, wr_count - w0);
    end
    disp_req = 1'b0;
    for (int c = 0; c < 40 && (wr_count - w0) < 5; c++) begin
      if (wi < 5) begin
        wr_valid = 1'b1;
        wr_addr  = 20'h00600 + 20'(wi);
        wr_data  = 16'hB000 + 16'(wi);
      end else begin
        wr_valid = 1'b0;
      end
      fire = wr_valid && wr_ready;
      tick;
      if (fire) wi++;
    end
    wr_valid = 1'b0;
    tick(2);
    checks++;
    if (wi != 5 || wr_count - w0 != 5) begin
      failures++;
      $display("FAIL buf_drain: got accepted=%0d writes=%0d want 5 5", wi, wr_count - w0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wlog.size() < 5 || wlog[wlog.size()-5+i] !== {20'h00600 + 20'(i), 16'hB000 + 16'(i)}) begin
        failures++;
        $display("FAIL buf_order_%0d: got %h want %h", i,
                 (wlog.size() < 5) ? 36'h0 : wlog[wlog.size()-5+i],
                 {20'h00600 + 20'(i), 16'hB000 + 16'(i)});
      end
    end
    checks++;
    if (overlap_cnt != 0) begin
      failures++;
      $display("FAIL buf_overlap: got %0d overlapping cycles want 0", overlap_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    disp_req  = 1'b0;
    disp_addr = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    test_reset();
    test_read_latency();
    test_back_to_back();
`ifndef SRAM_WR_BUFFER_EN
    test_write_blanking();
    test_contention();
    test_turnaround();
    test_reset_mid_op();
`else
    test_buffer();
`endif
    tick(3);
    checks++;
    if (sb.size() != 0 || overlap_cnt != 0) begin
      failures++;
      $display("FAIL final_state: got pending=%0d overlaps=%0d want 0 0", sb.size(), overlap_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
